// File: rtl/ctr_cnt_pkg.sv
// ctr_cnt_pkg: definitions shared by ctr_cnt_gen and ctr_cnt_dec.
//   ctr_state_e  - generator FSM state encoding
//   bitWidthCal  - count width for a given maximum value
//   val2En       - integer parameter to enable bit
//   idleCodeCal  - idle code for the selected range convention
package ctr_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } ctr_state_e;

  // ceil(log2(val)) + 1. The extra bit leaves the all-ones code strictly above
  // every legal count, so it can serve as a non-decoding idle value.
  function automatic int unsigned bitWidthCal(input int unsigned val);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) w = i + 1;
    end
    return w + 1;
  endfunction

  function automatic logic val2En(input int val);
    return (val != 0);
  endfunction

  // Zero-based ranges use 0 as a live count, so they idle at all-ones.
  function automatic logic [63:0] idleCodeCal(input logic zero_en, input int unsigned w);
    return zero_en ? ((64'd1 << w) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/ctr_cnt_gen.sv
// ctr_cnt_gen: count generator feeding ctr_cnt_dec. One start request emits
// CNT_VAL consecutive counts (zero- or one-based), then pulses done.
// Optional feature macro: CTR_CNT_GEN_AUTO_RELOAD_EN (passes repeat until abort/rst).
// Ports:
//   clk      clock
//   rst      synchronous reset, active-high
//   start    begin a pass (honoured in IDLE and DONE)
//   hold     pause advance while running
//   abort    terminate a pass without done
//   cnt_out  current count or IDLE_CODE (W bits)
//   cnt_vld  cnt_out carries a live count
//   busy     pass in progress (RUN or PAUSE)
//   last     cnt_out equals the final count
//   done     one-cycle completion pulse
module ctr_cnt_gen
  import ctr_cnt_pkg::*;
#(
  parameter string       OUTTER_NAME = "",
  parameter string       MODULE_NAME = "ctr_cnt_gen",
  parameter int          ZERO_VAL_EN = 0,
  parameter int unsigned CNT_VAL     = 1024,
  localparam int unsigned W = bitWidthCal(CNT_VAL + (val2En(ZERO_VAL_EN) ? 32'd1 : 32'd0))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         hold,
  input  logic         abort,
  output logic [W-1:0] cnt_out,
  output logic         cnt_vld,
  output logic         busy,
  output logic         last,
  output logic         done
);

  localparam int unsigned FIRST_I = val2En(ZERO_VAL_EN) ? 0 : 1;
  localparam int unsigned LAST_I  = FIRST_I + CNT_VAL - 1;

  localparam logic [W-1:0] FIRST     = W'(FIRST_I);
  localparam logic [W-1:0] LAST      = W'(LAST_I);
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] IDLE_CODE = W'(idleCodeCal(val2En(ZERO_VAL_EN), W));

  $info("ctr_cnt_gen banner: OUTTER_NAME=%s MODULE_NAME=%s ZERO_VAL_EN=%0d CNT_VAL=%0d W=%0d",
        OUTTER_NAME, MODULE_NAME, ZERO_VAL_EN, CNT_VAL, W);

  if (CNT_VAL < 1) begin : g_bad_cnt
    $error("ctr_cnt_gen: CNT_VAL must be at least 1");
  end

  ctr_state_e   state_q, state_d;
  logic [W-1:0] val_q, val_d;       // value on show in RUN, pending value in PAUSE
  logic [W-1:0] cnt_out_q, cnt_out_d;
  logic         cnt_vld_q, cnt_vld_d;
  logic         busy_q, busy_d;
  logic         last_q, last_d;
  logic         done_q, done_d;
  logic         reload;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    reload  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            val_d   = FIRST;
          end
        end
        ST_RUN: begin
          if (val_q == LAST) begin
`ifdef CTR_CNT_GEN_AUTO_RELOAD_EN
            val_d  = FIRST;
            reload = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end else begin
            // The increment happens even when pausing so PAUSE only has to
            // release the already-advanced value.
            val_d = val_q + ONE;
            if (hold) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!hold) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            val_d   = FIRST;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered: derive them from the state being entered.
    cnt_out_d = (state_d == ST_RUN) ? val_d : IDLE_CODE;
    cnt_vld_d = (state_d == ST_RUN);
    busy_d    = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    last_d    = (state_d == ST_RUN) && (val_d == LAST);
    done_d    = (state_d == ST_DONE) || reload;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      val_q     <= FIRST;
      cnt_out_q <= IDLE_CODE;
      cnt_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      cnt_out_q <= cnt_out_d;
      cnt_vld_q <= cnt_vld_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign cnt_out = cnt_out_q;
  assign cnt_vld = cnt_vld_q;
  assign busy    = busy_q;
  assign last    = last_q;
  assign done    = done_q;

endmodule
